// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage widths, FSM state and FIFO entry types
package mips_pkg;

  localparam int PC_W    = 30;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    KILL = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    incPC;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of fetched {instr, incPC} entries with flush
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           wdata,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC register and instruction-fetch stage with fetch FIFO
// Define FETCH_PERF_CNT_EN to add saturating redirect and decode-stall counters.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
)(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_PCSrc,
  input  logic [PC_W-1:0]    i_addr,
  output logic               o_imem_req,
  output logic [PC_W-1:0]    o_imem_addr,
  input  logic               i_imem_gnt,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_incPC,
  input  logic               i_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        o_redirect_cnt,
  output logic [31:0]        o_stall_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int UW = CW + 1;

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] req_inc_pc;
  logic            inflight;
  logic            req;
  logic            grant;
  logic            push;
  logic            pop;
  logic            nonempty;
  logic [CW-1:0]   count;
  logic [UW-1:0]   used;
  fetch_entry_t    head;
  fetch_entry_t    last_head;
  fetch_entry_t    push_entry;

  assign nonempty    = (count != '0);
  assign o_valid     = nonempty & ~i_PCSrc;
  assign pop         = o_valid & i_ready;
  assign grant       = req & i_imem_gnt;
  assign o_imem_req  = req;
  assign o_imem_addr = pc;
  assign o_instr     = nonempty ? head.instr : last_head.instr;
  assign o_incPC     = nonempty ? head.incPC : last_head.incPC;

  assign push_entry.instr = i_imem_rdata;
  assign push_entry.incPC = req_inc_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= BOOT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = RUN;
      RUN:     if (i_PCSrc && inflight) state_next = KILL;
      KILL:    state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  // A pop this cycle frees a slot, which keeps one fetch per cycle sustainable.
  always_comb begin
    used = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    req  = (state == RUN) && !i_PCSrc && (used < UW'(DEPTH));
    push = inflight && (state != KILL) && !i_PCSrc;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc         <= RESET_PC;
      inflight   <= 1'b0;
      req_inc_pc <= '0;
      last_head  <= '0;
    end else begin
      inflight <= grant;
      if (i_PCSrc)    pc <= i_addr;
      else if (grant) pc <= pc + PC_W'(1);
      if (grant)      req_inc_pc <= pc + PC_W'(1);
      if (nonempty)   last_head <= head;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .flush (i_PCSrc),
    .rdata (head),
    .count (count)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_redirect_cnt <= '0;
      o_stall_cnt    <= '0;
    end else begin
      if (i_PCSrc && (o_redirect_cnt != '1))           o_redirect_cnt <= o_redirect_cnt + 32'd1;
      if (o_valid && !i_ready && (o_stall_cnt != '1)) o_stall_cnt    <= o_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
